// File: rtl/imem_boot_loader.sv
// Arbitrates the single instruction BRAM port between CPU fetch and a byte-stream
// program loader that packs bytes little-endian into consecutive 32-bit words.
module imem_boot_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [1:0]        dbg_state
);

  // Counters must be able to hold both DEPTH and the full 8-bit load_len range.
  localparam int CW = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_wcnt;
  logic [1:0]       r_bcnt;
  logic [31:0]      r_pack;
  logic [CW-1:0]    r_len;
  logic             r_byte_ready;
  logic             r_cpu_stall;
  logic             r_load_done;
  logic             r_load_err;
  logic             r_mem_we;

  logic             w_len_ok;
  logic             w_accept;
  logic [CW-1:0]    w_wcnt_nxt;
  logic             w_last_word;
  logic             w_unused_addr;

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
  // byte_ready is high only in COLLECT, so a held byte_valid simply waits.
  assign w_len_ok    = (load_len != 8'd0) && ((CW+1)'(load_len) <= (CW+1)'(DEPTH));
  assign w_accept    = byte_valid && r_byte_ready;
  assign w_wcnt_nxt  = r_wcnt + CW'(1);
  assign w_last_word = (w_wcnt_nxt == r_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_wcnt       <= '0;
      r_bcnt       <= '0;
      r_pack       <= '0;
      r_len        <= '0;
      r_byte_ready <= 1'b0;
      r_cpu_stall  <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (load_start) begin
            if (w_len_ok) begin
              r_len        <= CW'(load_len);
              r_wcnt       <= '0;
              r_bcnt       <= '0;
              r_state      <= ST_COLLECT;
              r_byte_ready <= 1'b1;
              r_cpu_stall  <= 1'b1;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (w_accept) begin
            r_pack[{r_bcnt, 3'b000} +: 8] <= byte_data;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_state      <= ST_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_wcnt <= w_wcnt_nxt;
          if (w_last_word) begin
            r_state     <= ST_DONE;
            r_load_done <= 1'b1;
          end else begin
            r_state      <= ST_COLLECT;
            r_byte_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_RUN;
          r_cpu_stall <= 1'b0;
        end
        default: begin
          r_state      <= ST_RUN;
          r_byte_ready <= 1'b0;
          r_cpu_stall  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch owns the address only in RUN; the loader's word counter drives it otherwise.
  assign mem_addr    = (r_state == ST_RUN) ? fetch_addr[ADDR_W+1:2] : r_wcnt[ADDR_W-1:0];
  assign fetch_instr = (r_state == ST_RUN) ? mem_dout : 32'h0;
  assign mem_din     = r_pack;
  assign mem_we      = r_mem_we;
  assign byte_ready  = r_byte_ready;
  assign cpu_stall   = r_cpu_stall;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;
  assign dbg_state   = r_state;

  assign w_unused_addr = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: BRAM model on ~clk, randomized byte loads checked
// against a packed-word reference model and event logs.
module tb_imem_boot_loader;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk;
  logic              reset;
  logic              load_start;
  logic [7:0]        load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [31:0]       fetch_addr;
  logic [31:0]       fetch_instr;
  logic              cpu_stall;
  logic              load_done;
  logic              load_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  logic [1:0]        dbg_state;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .cpu_stall(cpu_stall),
    .load_done(load_done), .load_err(load_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int stall_low;

  logic [31:0]        mem [DEPTH];
  logic [7:0]         lbytes [512];
  int                 acc_cyc [512];
  logic [ADDR_W+31:0] got_q[$];
  int                 gotc_q[$];
  int                 done_q[$];
  int                 err_q[$];
  logic [ADDR_W+31:0] exp_q[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM clocked on ~clk
  always @(negedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // Event log: samples the cycle that is ending at each rising edge.
  always @(posedge clk) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_din});
      gotc_q.push_back(cyc);
    end
    if (load_done) done_q.push_back(cyc);
    if (load_err) err_q.push_back(cyc);
    cyc = cyc + 1;
  end

  function automatic logic [31:0] exp_word(input int k);
    return {lbytes[4*k+3], lbytes[4*k+2], lbytes[4*k+1], lbytes[4*k]};
  endfunction

  task automatic clear_logs();
    got_q.delete(); gotc_q.delete(); done_q.delete(); err_q.delete(); exp_q.delete();
  endtask

  task automatic rand_bytes(input int len);
    for (int i = 0; i < 4*len; i++) lbytes[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic start_load(input int len, output int scyc);
    @(posedge clk); #1;
    load_start = 1'b1;
    load_len   = 8'(len);
    @(negedge clk);
    scyc = cyc;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // gap_mode: 0 = back-to-back, 1 = valid toggles 1,0,1,0, 2 = random gaps
  task automatic feed_bytes(input int nb, input int gap_mode, input bit poke);
    int idx = 0;
    int budget = 0;
    bit tog = 1'b1;
    bit v, rdy;
    stall_low = 0;
    while (idx < nb && budget < 5000) begin
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? tog : 1'($urandom_range(0, 1));
      byte_valid = v;
      byte_data  = v ? lbytes[idx] : 8'($urandom_range(0, 255));
      if (poke) begin
        load_start = 1'($urandom_range(0, 1));
        load_len   = 8'd1;
      end
      @(negedge clk);
      rdy = byte_ready;
      if (!cpu_stall) stall_low++;
      if (v && rdy) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      @(posedge clk); #1;
      budget++;
      tog = ~tog;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    n_cmp++;
    if (idx !== nb) begin
      n_fail++;
      $display("FAIL feed_bytes: accepted %0d bytes, required %0d", idx, nb);
    end
  endtask

  task automatic check_load(input int len, input int scyc, input bit chk_timing, input string name);
    int k = 0;
    int dc;
    logic [ADDR_W+31:0] g, e;
    int gc;
    while (done_q.size() == 0 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    dc = (done_q.size() > 0) ? done_q[0] : -1;
    n_cmp++;
    if (done_q.size() != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d required 1", name, done_q.size());
    end
    n_cmp++;
    if (dc != acc_cyc[4*len-1] + 2) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, dc, acc_cyc[4*len-1] + 2);
    end
    if (chk_timing) begin
      n_cmp++;
      if (dc != scyc + 5*len + 1) begin
        n_fail++;
        $display("FAIL %s done_latency: got %0d required %0d", name, dc - scyc, 5*len + 1);
      end
    end
    n_cmp++;
    if (stall_low != 0) begin
      n_fail++;
      $display("FAIL %s stall_during_load: %0d cycles low, required 0", name, stall_low);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({cpu_stall, byte_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s after_done: stall=%b ready=%b required 0 0", name, cpu_stall, byte_ready);
    end
    n_cmp++;
    if (got_q.size() != len) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", name, got_q.size(), len);
    end
    for (int i = 0; i < len; i++) exp_q.push_back({7'(i), exp_word(i)});
    for (int i = 0; i < len; i++) begin
      e  = exp_q.pop_front();
      g  = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      gc = (gotc_q.size() > 0) ? gotc_q.pop_front() : -1;
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%h required addr=%0d data=%h",
                 name, i, g[ADDR_W+31:32], g[31:0], e[ADDR_W+31:32], e[31:0]);
      end
      n_cmp++;
      if (gc != acc_cyc[4*i+3] + 1) begin
        n_fail++;
        $display("FAIL %s write_cycle[%0d]: got %0d required %0d", name, i, gc, acc_cyc[4*i+3] + 1);
      end
      n_cmp++;
      if (mem[i] !== exp_word(i)) begin
        n_fail++;
        $display("FAIL %s bram[%0d]: got %h required %h", name, i, mem[i], exp_word(i));
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({byte_ready, cpu_stall, load_done, load_err, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 00000",
               {byte_ready, cpu_stall, load_done, load_err, mem_we});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (fetch_instr !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL reset_fetch: got %h required DEADBEEF", fetch_instr);
    end
    n_cmp++;
    if ({cpu_stall, byte_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: stall=%b ready=%b required 0 0", cpu_stall, byte_ready);
    end
    for (int i = 0; i < 4; i++) begin
      int w = $urandom_range(0, DEPTH-1);
      mem[w] = $urandom;
      @(posedge clk); #1;
      fetch_addr = {$urandom_range(0, 32'h7F_FFFF), 7'(w), 2'($urandom_range(0, 3))};
      @(negedge clk); #1;
      n_cmp++;
      if (fetch_instr !== mem[w]) begin
        n_fail++;
        $display("FAIL fetch_word%0d: got %h required %h", w, fetch_instr, mem[w]);
      end
    end
  endtask

  task automatic test_spec_load(input int gap_mode, input bit poke, input string name);
    int s;
    clear_logs();
    for (int i = 0; i < 8; i++) lbytes[i] = 8'(8'h11 * (i + 1));
    start_load(2, s);
    feed_bytes(8, gap_mode, poke);
    check_load(2, s, gap_mode == 0, name);
  endtask

  task automatic test_random_loads();
    int s, len;
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      len = $urandom_range(1, 6);
      rand_bytes(len);
      start_load(len, s);
      feed_bytes(4*len, 2, 1'b1);
      check_load(len, s, 1'b0, "random_load");
    end
  endtask

  task automatic test_load_err();
    int lens[3] = '{0, 200, 129};
    int s;
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      start_load(lens[i], s);
      @(negedge clk); #1;
      n_cmp++;
      if ({load_err, cpu_stall, byte_ready} !== 3'b100) begin
        n_fail++;
        $display("FAIL load_err len=%0d: err/stall/ready=%b required 100",
                 lens[i], {load_err, cpu_stall, byte_ready});
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (err_q.size() != 1 || got_q.size() != 0) begin
        n_fail++;
        $display("FAIL load_err_pulse len=%0d: errs=%0d writes=%0d required 1 0",
                 lens[i], err_q.size(), got_q.size());
      end
    end
  endtask

  task automatic test_mid_reset();
    int s;
    logic [31:0] old1;
    clear_logs();
    old1 = $urandom;
    mem[1] = old1;
    rand_bytes(2);
    start_load(2, s);
    feed_bytes(6, 0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, cpu_stall, load_done, load_err, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b required 00000",
               {byte_ready, cpu_stall, load_done, load_err, mem_we});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (done_q.size() != 0 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL mid_reset_events: done=%0d writes=%0d required 0 1", done_q.size(), got_q.size());
    end
    n_cmp++;
    if (mem[0] !== exp_word(0)) begin
      n_fail++;
      $display("FAIL mid_reset_word0: got %h required %h", mem[0], exp_word(0));
    end
    n_cmp++;
    if (mem[1] !== old1) begin
      n_fail++;
      $display("FAIL mid_reset_word1: got %h required %h", mem[1], old1);
    end
  endtask

  task automatic test_full_load();
    int s;
    clear_logs();
    rand_bytes(DEPTH);
    start_load(DEPTH, s);
    feed_bytes(4*DEPTH, 0, 1'b0);
    check_load(DEPTH, s, 1'b1, "full_load");
    @(posedge clk); #1;
    fetch_addr = 32'h0000_01FC;
    @(negedge clk); #1;
    n_cmp++;
    if (fetch_instr !== exp_word(DEPTH-1)) begin
      n_fail++;
      $display("FAIL full_fetch127: got %h required %h", fetch_instr, exp_word(DEPTH-1));
    end
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    load_len   = 8'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    fetch_addr = 32'hABCD_E00B;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[2] = 32'hDEADBEEF;
    test_reset();
    test_spec_load(0, 1'b0, "back_to_back");
    test_spec_load(1, 1'b1, "toggled_valid");
    test_random_loads();
    test_load_err();
    test_mid_reset();
    test_full_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
